dragon_body_controller: RTL
===========================

Name: dragon_body_controller

Overview:
- Producer of the packed dragon-body interface consumed by the game-state collision unit: `dragonSegmentPositions[55:0]` plus the `activeDragonSegments[6:0]` mask.
- Tracks up to 7 segments as a shift chain fed by the dragon head position on each movement tick, and manages length (grow/shrink) and the defeat condition.
- Publishes a tear-free snapshot once per frame so the collision scanner never sees a half-updated body.

Parameters:
- INIT_LEN, 1, segment count after reset (1..7).
- INIT_HEAD_POS, 8'h00, position loaded into every segment slot at reset.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- move_tick  input  1  one-cycle pulse: dragon advances one cell
- head_pos  input  8  new head position, sampled on move_tick; [7:4]=y row, [3:0]=x column
- grow  input  1  one-cycle pulse: request one extra segment
- shrink  input  1  one-cycle pulse: dragon hit, remove one segment
- frame_sync  input  1  one-cycle pulse at start of each collision scan/frame
- dragonSegmentPositions  output  56  published positions, segment i at [8i+7:8i], segment 0 = head
- activeDragonSegments  output  7  published thermometer mask, bit i = segment i active
- segment_count  output  3  published length 0..7
- update_valid  output  1  one-cycle pulse the cycle after a publish
- dragon_defeated  output  1  sticky, published defeat flag

Behaviour:
- Reset, synchronous active-high, overrides all other inputs:
  - internal and published slots = INIT_HEAD_POS.
  - length = INIT_LEN; published mask = (1<<INIT_LEN)-1.
  - segment_count = INIT_LEN; grow_pending = 0; state = ALIVE; dragon_defeated = 0; update_valid = 0.
- Reset mid-frame discards any unpublished move.
- Internal body: 7×8-bit shift chain `seg[0..6]`, 3-bit length, 1-bit grow_pending. FSM states ALIVE and DEFEATED.
- ALIVE, move_tick:
  - seg[0] <= head_pos; seg[i] <= seg[i-1] for i = 1..6.
  - All 7 slots shift regardless of length, so a newly activated tail slot already holds the previous tail position.
- Growth:
  - grow sets grow_pending; it stays set until applied.
  - Applied on the next move_tick: length += 1 if length < 7, and grow_pending clears.
  - At length 7 the pending grow is dropped, i.e. cleared without effect.
  - grow and move_tick in the same cycle: the grow is applied on that tick.
- Shrink:
  - Immediate, not tied to move_tick: length -= 1 if length > 1.
  - shrink at length 1: length becomes 0 and state goes to DEFEATED.
  - shrink and grow in the same cycle: both cancel; length and grow_pending are unchanged.
  - shrink and move_tick in the same cycle: shift occurs and length decrements; any pending grow is still applied, giving net length unchanged.
- DEFEATED (terminal until reset):
  - move_tick, grow and shrink are ignored; the chain is frozen.
  - Internal length = 0, so the mask publishes as 0.
- Publish: on frame_sync, output registers <= internal state as it stood before any same-cycle update.
  - Updated together: positions, mask = (1<<length)-1 as 7 bits, segment_count, and dragon_defeated = (state==DEFEATED).
  - A move_tick coinciding with frame_sync is visible only at the next frame_sync.
  - update_valid = 1 the cycle after each frame_sync, otherwise 0.
- Outputs are registered only; they are constant between frame_syncs.
- Latency: move_tick at cycle N updates internal state at N+1. Visibility: outputs change at the first frame_sync strictly after N, and update_valid rises one cycle after that.
- Widths: length is 3-bit and never wraps; it saturates at 7 and floors at 0. Positions are passed through unmodified, with no range check.

Test Plan:
- Reset with INIT_LEN=3, INIT_HEAD_POS=8'h45, then frame_sync → positions all 8'h45, mask 7'b0000111, count 3, update_valid pulses once, defeated 0.
- Three move_ticks with head_pos 8'h11, 8'h22, 8'h33, then frame_sync → seg0=33, seg1=22, seg2=11, seg3..6=45, mask unchanged 7'b0000111.
- Length 3, grow pulse, then move_tick with head 8'h44, then frame_sync → count 4, mask 7'b0001111, seg3 = old seg2 value. Repeat grow at length 7 → count stays 7, grow_pending cleared.
- Length 2: shrink+grow in the same cycle → count 2. shrink → count 1. shrink → count 0, mask 0, dragon_defeated 1 after frame_sync; further move_ticks leave positions frozen.
- move_tick with head 8'h5A in the same cycle as frame_sync → published seg0 keeps its old value; next frame_sync publishes 8'h5A.
- Reset asserted between a move_tick and frame_sync → next publish shows reset values only; update_valid never asserts without a preceding frame_sync.

Source files
------------

// File: rtl/dragon_body_controller.sv
// Dragon body tracker: shift chain of segment positions, length and defeat,
// published as a frame-coherent snapshot for the collision scanner.
module dragon_body_controller #(
    parameter int         INIT_LEN      = 1,
    parameter logic [7:0] INIT_HEAD_POS = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_tick,
    input  logic [7:0]  head_pos,
    input  logic        grow,
    input  logic        shrink,
    input  logic        frame_sync,
    output logic [55:0] dragonSegmentPositions,
    output logic [6:0]  activeDragonSegments,
    output logic [2:0]  segment_count,
    output logic        update_valid,
    output logic        dragon_defeated
);

    localparam logic [0:0] ST_ALIVE    = 1'b0;
    localparam logic [0:0] ST_DEFEATED = 1'b1;

    localparam logic [2:0]  INIT_LEN_W  = 3'(INIT_LEN);
    localparam logic [7:0]  INIT_MASK_W = 8'((1 << INIT_LEN) - 1);
    localparam logic [55:0] INIT_SEGS   = {7{INIT_HEAD_POS}};

    logic [0:0]  r_state;
    logic [55:0] r_seg;
    logic [2:0]  r_length;
    logic        r_grow_pending;

    logic        w_alive;
    logic        w_tick;
    logic        w_grow_req;
    logic        w_inc;
    logic        w_dec;
    logic        w_defeat;
    logic [2:0]  w_length_nxt;
    logic        w_pending_nxt;
    logic [7:0]  w_mask_wide;
    logic [6:0]  w_mask;

    // Movement, growth and shrink decisions for this cycle
    always_comb begin
        w_alive    = (r_state == ST_ALIVE);
        w_tick     = w_alive & move_tick;
        // A grow coinciding with a shrink is cancelled by it
        w_grow_req = r_grow_pending | (grow & ~shrink);
        w_inc      = w_tick & w_grow_req & (r_length != 3'd7);
        w_dec      = w_alive & shrink & ~grow;
        w_defeat   = w_dec & ~w_inc & (r_length == 3'd1);
    end

    // Next length: grow on tick and shrink may offset each other
    always_comb begin
        w_length_nxt = r_length;
        unique case ({w_inc, w_dec})
            2'b10:   w_length_nxt = r_length + 3'd1;
            2'b01:   w_length_nxt = r_length - 3'd1;
            default: w_length_nxt = r_length;
        endcase
    end

    // Pending grow is consumed (or dropped at full length) by any tick
    always_comb begin
        w_pending_nxt = r_grow_pending;
        if (!w_alive) begin
            w_pending_nxt = 1'b0;
        end else if (w_tick) begin
            w_pending_nxt = 1'b0;
        end else if (grow && !shrink) begin
            w_pending_nxt = 1'b1;
        end
    end

    // Thermometer mask of the current internal length
    always_comb begin
        w_mask_wide = (8'd1 << r_length) - 8'd1;
        w_mask      = w_mask_wide[6:0];
    end

    // Internal body: chain shift, length and life state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_ALIVE;
            r_seg          <= INIT_SEGS;
            r_length       <= INIT_LEN_W;
            r_grow_pending <= 1'b0;
        end else if (w_alive) begin
            if (w_tick) begin
                r_seg <= {r_seg[47:0], head_pos};
            end
            r_grow_pending <= w_pending_nxt;
            if (w_defeat) begin
                r_state  <= ST_DEFEATED;
                r_length <= 3'd0;
            end else begin
                r_length <= w_length_nxt;
            end
        end else begin
            r_length       <= 3'd0;
            r_grow_pending <= 1'b0;
        end
    end

    // Snapshot of pre-update internal state on each frame_sync
    always_ff @(posedge clk) begin
        if (reset) begin
            dragonSegmentPositions <= INIT_SEGS;
            activeDragonSegments   <= INIT_MASK_W[6:0];
            segment_count          <= INIT_LEN_W;
            dragon_defeated        <= 1'b0;
        end else if (frame_sync) begin
            dragonSegmentPositions <= r_seg;
            activeDragonSegments   <= w_mask;
            segment_count          <= r_length;
            dragon_defeated        <= (r_state == ST_DEFEATED);
        end
    end

    // Publish strobe, one cycle after frame_sync
    always_ff @(posedge clk) begin
        if (reset) begin
            update_valid <= 1'b0;
        end else begin
            update_valid <= frame_sync;
        end
    end

endmodule
